// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI peripheral-side endpoint. SCLK, SS and MOSI are oversampled in the clk
// domain. Received bits are assembled MSB first into RX_DATA, with a one-clk
// RX_VALID pulse per completed word. MISO is driven from a shift register that
// is fed by a single-entry transmit buffer. Any number of back-to-back words
// may be sent within one SS frame.
//
// Parameters:
//   DATA_WIDTH  bits per SPI word (>= 2)
//   CPOL        SCLK idle level
//   CPHA        0: sample on leading edge, shift on trailing edge
//               1: shift on leading edge, sample on trailing edge
//   DEFAULT_TX  word shifted out when the TX buffer is empty at word start
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   SCLK, SS, MOSI      SPI bus inputs (asynchronous to clk, SS active low)
//   MISO, MISO_OE       slave data out (0 while MISO_OE low), output enable
//   TX_VALID/TX_READY   transmit buffer handshake, TX_DATA is the word
//   RX_DATA, RX_VALID   last received word, one-clk update pulse
//   TX_UNDERRUN         one-clk pulse when DEFAULT_TX is used for a word
//   BUSY                frame active
//   fsm_state           current FSM state (debug visibility)
//
// Handshake: a word moves from TX_DATA into the buffer on every rising clk
// edge where TX_VALID and TX_READY are both high. TX_READY is high exactly
// when the buffer is empty; TX_VALID may be held across cycles and TX_DATA
// must be stable while TX_VALID is high. There is no backpressure on RX:
// RX_DATA is overwritten by every completed word.
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter int                    DATA_WIDTH = 8,
  parameter bit                    CPOL       = 1'b0,
  parameter bit                    CPHA       = 1'b0,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCLK,
  input  logic                  SS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  input  logic                  TX_VALID,
  output logic                  TX_READY,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_VALID,
  output logic                  TX_UNDERRUN,
  output logic                  BUSY,
  output logic [1:0]            fsm_state
);

  localparam int            CW       = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Synchronisers. SS resets to "selected" so that a reset in the middle of a
  // frame cannot be mistaken for an idle bus: WAIT_IDLE only leaves once the
  // real pin has been seen high.
  // ---------------------------------------------------------------------------
  logic [2:0] sclk_sync;
  logic [2:0] ss_sync;
  logic [1:0] mosi_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= {3{CPOL}};
      ss_sync   <= 3'b000;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], SCLK};
      ss_sync   <= {ss_sync[1:0], SS};
      mosi_sync <= {mosi_sync[0], MOSI};
    end
  end

  logic sclk_now, sclk_prev, sclk_edge, lead_edge, trail_edge;
  logic ss_now, ss_fall, mosi_now;
  logic sample_edge, shift_edge;

  assign sclk_now    = sclk_sync[1];
  assign sclk_prev   = sclk_sync[2];
  assign sclk_edge   = sclk_now ^ sclk_prev;
  assign lead_edge   = sclk_edge & (sclk_now != CPOL);
  assign trail_edge  = sclk_edge & (sclk_now == CPOL);
  assign ss_now      = ss_sync[1];
  assign ss_fall     = ~ss_sync[1] & ss_sync[2];
  assign mosi_now    = mosi_sync[1];
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic frame_start, frame_end, sample_en, shift_en;

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    sample_en   = 1'b0;
    shift_en    = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (ss_now) state_nxt = IDLE;
      end
      IDLE: begin
        if (ss_fall) begin
          state_nxt   = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_now) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end else begin
          sample_en = sample_edge;
          shift_en  = shift_edge;
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] tx_buf, tx_shift, load_val, rx_word, rx_data_q;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [CW-1:0]         bit_cnt;
  logic                  tx_full, miso_q, need_load, und_pend;
  logic                  rx_valid_q, tx_underrun_q;
  logic                  word_done, load_word;

  assign word_done = sample_en & (bit_cnt == LAST_BIT);
  // CPHA=1 defers the load of every word after the first to its first
  // leading edge, which is where that word's MSB is put on MISO.
  assign load_word = frame_start | (CPHA ? (shift_en & need_load) : word_done);
  // A load always sees the buffer as it was before this edge, so a word
  // arriving on the same edge is kept for the next load.
  assign load_val  = tx_full ? tx_buf : DEFAULT_TX;
  assign rx_word   = {rx_shift, mosi_now};

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_buf        <= '0;
      tx_full       <= 1'b0;
      tx_shift      <= '0;
      miso_q        <= 1'b0;
      need_load     <= 1'b0;
      und_pend      <= 1'b0;
      rx_shift      <= '0;
      bit_cnt       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;

      if (TX_VALID && !tx_full) begin
        tx_buf  <= TX_DATA;
        tx_full <= 1'b1;
      end
      if (load_word && tx_full) tx_full <= 1'b0;

      if (frame_start) begin
        tx_shift      <= load_val;
        tx_underrun_q <= ~tx_full;
        bit_cnt       <= '0;
        miso_q        <= 1'b0;
        need_load     <= 1'b0;
        und_pend      <= 1'b0;
      end

      // Partial words are dropped; the next frame starts at bit 0.
      if (frame_end) begin
        bit_cnt   <= '0;
        need_load <= 1'b0;
        und_pend  <= 1'b0;
      end

      if (sample_en) begin
        rx_shift <= rx_word[DATA_WIDTH-2:0];
        // CPHA=0 loads the next word as soon as the previous one completes,
        // but an underrun is only reported once that word is really clocked,
        // so a frame ending on a word boundary does not report one.
        if (und_pend && bit_cnt == '0) begin
          tx_underrun_q <= 1'b1;
          und_pend      <= 1'b0;
        end
        if (bit_cnt == LAST_BIT) begin
          bit_cnt    <= '0;
          rx_data_q  <= rx_word;
          rx_valid_q <= 1'b1;
          if (CPHA) begin
            need_load <= 1'b1;
          end else begin
            tx_shift <= load_val;
            und_pend <= ~tx_full;
          end
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end

      if (shift_en) begin
        if (CPHA) begin
          if (need_load) begin
            miso_q        <= load_val[DATA_WIDTH-1];
            tx_shift      <= {load_val[DATA_WIDTH-2:0], 1'b0};
            need_load     <= 1'b0;
            tx_underrun_q <= ~tx_full;
          end else begin
            miso_q   <= tx_shift[DATA_WIDTH-1];
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
          end
        end else if (bit_cnt != '0) begin
          // The trailing edge right after a word's last bit must not shift:
          // the next word was loaded on that last sample edge.
          tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign MISO_OE     = (state == ACTIVE);
  assign BUSY        = (state == ACTIVE);
  assign MISO        = MISO_OE & (CPHA ? miso_q : tx_shift[DATA_WIDTH-1]);
  assign TX_READY    = ~tx_full;
  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rx_valid_q;
  assign TX_UNDERRUN = tx_underrun_q;
  assign fsm_state   = state;

endmodule
